// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage RV32 pipeline: EX/D forwarding, load-use and branch
// stalls, a pending-write scoreboard for the out-of-order long-latency unit, and a stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,

  input  logic [REG_ADDR_W-1:0]        i_rs1_D,
  input  logic [REG_ADDR_W-1:0]        i_rs2_D,
  input  logic [REG_ADDR_W-1:0]        i_rd_D,
  input  logic                         i_branch_D,
  input  logic                         i_wr_en_D,
  input  logic                         i_long_op_D,

  input  logic [REG_ADDR_W-1:0]        i_rs1_E,
  input  logic [REG_ADDR_W-1:0]        i_rs2_E,

  input  logic                         i_register_file_wr_en_E,
  input  logic                         i_register_file_wr_en_M,
  input  logic                         i_register_file_wr_en_W,
  input  logic [REG_ADDR_W-1:0]        i_register_file_wr_addr_E,
  input  logic [REG_ADDR_W-1:0]        i_register_file_wr_addr_M,
  input  logic [REG_ADDR_W-1:0]        i_register_file_wr_addr_W,
  input  logic                         i_sel_result_E,
  input  logic                         i_sel_result_M,

  input  logic                         i_long_issue_E,
  input  logic                         i_long_busy,
  input  logic                         i_long_wb_valid,
  input  logic [REG_ADDR_W-1:0]        i_long_wb_addr,

  output logic                         o_stall_F,
  output logic                         o_stall_D,
  output logic                         o_flush_E,
  output logic                         o_fwdA_D,
  output logic                         o_fwdB_D,
  output logic [1:0]                   o_fwdA_E,
  output logic [1:0]                   o_fwdB_E,
  output logic [(2**REG_ADDR_W)-1:0]   o_pending,
  output logic [STALL_CNT_W-1:0]       o_stall_count
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0]  X0      = '0;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_LONG = 2'b11;

  logic [NUM_REGS-1:0]    pending_q, pending_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lw_stall, branch_stall, sb_stall, struct_stall, stall;

  // The M slot outranks the long writeback because it is the younger producer of the value.
  function automatic logic [1:0] fwd_sel_e(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wen_m,
    input logic [REG_ADDR_W-1:0] addr_m,
    input logic                  load_m,
    input logic                  long_v,
    input logic [REG_ADDR_W-1:0] long_addr,
    input logic                  wen_w,
    input logic [REG_ADDR_W-1:0] addr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != X0) begin
      if (wen_m && addr_m == src && !load_m)  sel = FWD_M;
      else if (long_v && long_addr == src)    sel = FWD_LONG;
      else if (wen_w && addr_w == src)        sel = FWD_W;
    end
    return sel;
  endfunction

  // A branch source depends on an ALU result still in E or a load value still in M.
  function automatic logic branch_dep(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wen_e,
    input logic [REG_ADDR_W-1:0] addr_e,
    input logic                  load_m,
    input logic [REG_ADDR_W-1:0] addr_m
  );
    return (src != X0) && ((wen_e && addr_e == src) || (load_m && addr_m == src));
  endfunction

  // NOTE: purely combinational logic uses always_comb with a default assigned first, so no latch can form.
  always_comb begin
    o_fwdA_E = fwd_sel_e(i_rs1_E,
                         i_register_file_wr_en_M, i_register_file_wr_addr_M, i_sel_result_M,
                         i_long_wb_valid, i_long_wb_addr,
                         i_register_file_wr_en_W, i_register_file_wr_addr_W);
    o_fwdB_E = fwd_sel_e(i_rs2_E,
                         i_register_file_wr_en_M, i_register_file_wr_addr_M, i_sel_result_M,
                         i_long_wb_valid, i_long_wb_addr,
                         i_register_file_wr_en_W, i_register_file_wr_addr_W);
  end

  always_comb begin
    o_fwdA_D = (i_rs1_D != X0) && (i_rs1_D == i_register_file_wr_addr_M) &&
               i_register_file_wr_en_M && !i_sel_result_M;
    o_fwdB_D = (i_rs2_D != X0) && (i_rs2_D == i_register_file_wr_addr_M) &&
               i_register_file_wr_en_M && !i_sel_result_M;
  end

  always_comb begin
    lw_stall = i_sel_result_E && (i_register_file_wr_addr_E != X0) &&
               ((i_register_file_wr_addr_E == i_rs1_D) || (i_register_file_wr_addr_E == i_rs2_D));

    branch_stall = i_branch_D &&
      (branch_dep(i_rs1_D, i_register_file_wr_en_E, i_register_file_wr_addr_E,
                  i_sel_result_M, i_register_file_wr_addr_M) ||
       branch_dep(i_rs2_D, i_register_file_wr_en_E, i_register_file_wr_addr_E,
                  i_sel_result_M, i_register_file_wr_addr_M));

    // Registered bits only: a same-cycle writeback still stalls, the reader picks it up next cycle.
    sb_stall = pending_q[i_rs1_D] || pending_q[i_rs2_D] ||
               (i_wr_en_D && pending_q[i_rd_D]);

    struct_stall = i_long_op_D && (i_long_busy || i_long_issue_E);

    stall = lw_stall || branch_stall || sb_stall || struct_stall;
  end

  assign o_stall_F = stall;
  assign o_stall_D = stall;
  assign o_flush_E = stall;

  // Clear first, then set, so an issue and a writeback to the same register leave it pending.
  always_comb begin
    pending_d = pending_q;
    if (i_long_wb_valid) begin
      pending_d[i_long_wb_addr] = 1'b0;
    end
    if (i_long_issue_E && (i_register_file_wr_addr_E != X0)) begin
      pending_d[i_register_file_wr_addr_E] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments and clear on the asynchronous reset edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_pending     = pending_q;
  assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus pushes model predictions, a negedge monitor
// pops and compares; a second instance with a 2-bit counter covers saturation.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, a_e, a_m, a_w, wb_addr;
  logic branch_d, wr_en_d, long_op_d, we_e, we_m, we_w, sel_e, sel_m;
  logic long_issue_e, long_busy, wb_valid;

  logic          stall_f, stall_d, flush_e, fwda_d, fwdb_d;
  logic [1:0]    fwda_e, fwdb_e;
  logic [NR-1:0] pend;
  logic [31:0]   cnt;

  logic          s_stall_f, s_stall_d, s_flush_e, s_fwda_d, s_fwdb_d;
  logic [1:0]    s_fwda_e, s_fwdb_e;
  logic [NR-1:0] s_pend;
  logic [1:0]    s_cnt;

  hazard_scoreboard #(.REG_ADDR_W(AW), .STALL_CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_D(rs1_d), .i_rs2_D(rs2_d), .i_rd_D(rd_d),
    .i_branch_D(branch_d), .i_wr_en_D(wr_en_d), .i_long_op_D(long_op_d),
    .i_rs1_E(rs1_e), .i_rs2_E(rs2_e),
    .i_register_file_wr_en_E(we_e), .i_register_file_wr_en_M(we_m), .i_register_file_wr_en_W(we_w),
    .i_register_file_wr_addr_E(a_e), .i_register_file_wr_addr_M(a_m), .i_register_file_wr_addr_W(a_w),
    .i_sel_result_E(sel_e), .i_sel_result_M(sel_m),
    .i_long_issue_E(long_issue_e), .i_long_busy(long_busy),
    .i_long_wb_valid(wb_valid), .i_long_wb_addr(wb_addr),
    .o_stall_F(stall_f), .o_stall_D(stall_d), .o_flush_E(flush_e),
    .o_fwdA_D(fwda_d), .o_fwdB_D(fwdb_d), .o_fwdA_E(fwda_e), .o_fwdB_E(fwdb_e),
    .o_pending(pend), .o_stall_count(cnt)
  );

  hazard_scoreboard #(.REG_ADDR_W(AW), .STALL_CNT_W(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_D(rs1_d), .i_rs2_D(rs2_d), .i_rd_D(rd_d),
    .i_branch_D(branch_d), .i_wr_en_D(wr_en_d), .i_long_op_D(long_op_d),
    .i_rs1_E(rs1_e), .i_rs2_E(rs2_e),
    .i_register_file_wr_en_E(we_e), .i_register_file_wr_en_M(we_m), .i_register_file_wr_en_W(we_w),
    .i_register_file_wr_addr_E(a_e), .i_register_file_wr_addr_M(a_m), .i_register_file_wr_addr_W(a_w),
    .i_sel_result_E(sel_e), .i_sel_result_M(sel_m),
    .i_long_issue_E(long_issue_e), .i_long_busy(long_busy),
    .i_long_wb_valid(wb_valid), .i_long_wb_addr(wb_addr),
    .o_stall_F(s_stall_f), .o_stall_D(s_stall_d), .o_flush_E(s_flush_e),
    .o_fwdA_D(s_fwda_d), .o_fwdB_D(s_fwdb_d), .o_fwdA_E(s_fwda_e), .o_fwdB_E(s_fwdb_e),
    .o_pending(s_pend), .o_stall_count(s_cnt)
  );

  typedef struct {
    logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, a_e, a_m, a_w, wb_addr;
    logic branch_d, wr_en_d, long_op_d, we_e, we_m, we_w, sel_e, sel_m;
    logic long_issue_e, long_busy, wb_valid;
  } stim_t;

  typedef struct {
    logic          stall, fwda_d, fwdb_d;
    logic [1:0]    fwda_e, fwdb_e;
    logic [NR-1:0] pend;
    logic [31:0]   cnt;
    logic [1:0]    cnt_s;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: pending set per register, unbounded count, and the 2-bit saturating count.
  logic [NR-1:0] m_pend;
  int            m_cnt;
  int            m_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [AW-1:0] src, input stim_t s);
    if (src == 0)                               return 2'b00;
    if (s.we_m && s.a_m == src && !s.sel_m)     return 2'b10;
    if (s.wb_valid && s.wb_addr == src)         return 2'b11;
    if (s.we_w && s.a_w == src)                 return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_fwd_d(input logic [AW-1:0] src, input stim_t s);
    return (src != 0) && (src == s.a_m) && s.we_m && !s.sel_m;
  endfunction

  function automatic logic m_br_dep(input logic [AW-1:0] src, input stim_t s);
    return (src != 0) && ((s.we_e && s.a_e == src) || (s.sel_m && s.a_m == src));
  endfunction

  function automatic logic m_stall(input stim_t s);
    logic lw, br, sb, st;
    lw = s.sel_e && (s.a_e != 0) && (s.a_e == s.rs1_d || s.a_e == s.rs2_d);
    br = s.branch_d && (m_br_dep(s.rs1_d, s) || m_br_dep(s.rs2_d, s));
    sb = m_pend[s.rs1_d] || m_pend[s.rs2_d] || (s.wr_en_d && m_pend[s.rd_d]);
    st = s.long_op_d && (s.long_busy || s.long_issue_e);
    return lw || br || sb || st;
  endfunction

  // Drive one cycle of inputs, queue the prediction for this cycle, then advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    rs1_d = s.rs1_d; rs2_d = s.rs2_d; rd_d = s.rd_d;
    branch_d = s.branch_d; wr_en_d = s.wr_en_d; long_op_d = s.long_op_d;
    rs1_e = s.rs1_e; rs2_e = s.rs2_e;
    we_e = s.we_e; we_m = s.we_m; we_w = s.we_w;
    a_e = s.a_e; a_m = s.a_m; a_w = s.a_w;
    sel_e = s.sel_e; sel_m = s.sel_m;
    long_issue_e = s.long_issue_e; long_busy = s.long_busy;
    wb_valid = s.wb_valid; wb_addr = s.wb_addr;

    e.stall  = m_stall(s);
    e.fwda_d = m_fwd_d(s.rs1_d, s);
    e.fwdb_d = m_fwd_d(s.rs2_d, s);
    e.fwda_e = m_fwd_e(s.rs1_e, s);
    e.fwdb_e = m_fwd_e(s.rs2_e, s);
    e.pend   = m_pend;
    e.cnt    = m_cnt;
    e.cnt_s  = m_cnt_s[1:0];
    exp_q.push_back(e);

    if (s.wb_valid) m_pend[s.wb_addr] = 1'b0;
    if (s.long_issue_e && s.a_e != 0) m_pend[s.a_e] = 1'b1;
    if (e.stall) begin
      m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    #1;
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rs1_d = raddr(); s.rs2_d = raddr(); s.rd_d = raddr();
    s.rs1_e = raddr(); s.rs2_e = raddr();
    s.a_e = raddr(); s.a_m = raddr(); s.a_w = raddr(); s.wb_addr = raddr();
    s.branch_d     = ($urandom_range(0, 3) == 0);
    s.wr_en_d      = ($urandom_range(0, 1) == 0);
    s.long_op_d    = ($urandom_range(0, 5) == 0);
    s.we_e         = ($urandom_range(0, 1) == 0);
    s.we_m         = ($urandom_range(0, 1) == 0);
    s.we_w         = ($urandom_range(0, 1) == 0);
    s.sel_e        = ($urandom_range(0, 4) == 0);
    s.sel_m        = ($urandom_range(0, 4) == 0);
    s.long_issue_e = ($urandom_range(0, 3) == 0);
    s.long_busy    = ($urandom_range(0, 2) == 0);
    s.wb_valid     = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_F", 64'(stall_f), 64'(e.stall));
      check("stall_D", 64'(stall_d), 64'(e.stall));
      check("flush_E", 64'(flush_e), 64'(e.stall));
      check("fwdA_D", 64'(fwda_d), 64'(e.fwda_d));
      check("fwdB_D", 64'(fwdb_d), 64'(e.fwdb_d));
      check("fwdA_E", 64'(fwda_e), 64'(e.fwda_e));
      check("fwdB_E", 64'(fwdb_e), 64'(e.fwdb_e));
      check("pending", 64'(pend), 64'(e.pend));
      check("stall_count", 64'(cnt), 64'(e.cnt));
      check("stall_count_w2", 64'(s_cnt), 64'(e.cnt_s));
      check("stall_w2", 64'(s_stall_d), 64'(e.stall));
    end
  end

  initial begin
    stim_t s;
    m_pend = '0; m_cnt = 0; m_cnt_s = 0;
    rst_n = 1'b0;
    s = idle();
    apply(s);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    check("reset_pending", 64'(pend), 64'd0);
    check("reset_count", 64'(cnt), 64'd0);
    #1 rst_n = 1'b1;

    // Build pending[5] and seven stall cycles, then reset between clock edges.
    s = idle(); s.long_issue_e = 1'b1; s.a_e = 5; step(s);
    s = idle(); s.long_op_d = 1'b1; s.long_busy = 1'b1;
    repeat (7) step(s);
    s = idle(); step(s);
    check("pre_reset_count", 64'(cnt), 64'd7);
    check("pre_reset_pending", 64'(pend), 64'h20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_pending", 64'(pend), 64'd0);
    check("async_reset_count", 64'(cnt), 64'd0);
    check("async_reset_count_w2", 64'(s_cnt), 64'd0);
    #1 rst_n = 1'b1;
    m_pend = '0; m_cnt = 0; m_cnt_s = 0;

    // Branch on x6 produced in E, then forwarded from M; counter saturation.
    s = idle(); s.branch_d = 1'b1; s.rs1_d = 2; s.rs2_d = 6; s.we_e = 1'b1; s.a_e = 6; step(s);
    check("branch_stall", 64'(stall_d), 64'd1);
    s = idle(); s.branch_d = 1'b1; s.rs1_d = 2; s.rs2_d = 6; s.we_m = 1'b1; s.a_m = 6; step(s);
    check("branch_release", 64'(stall_d), 64'd0);
    check("branch_fwdB_D", 64'(fwdb_d), 64'd1);
    s = idle(); s.long_op_d = 1'b1; s.long_issue_e = 1'b1; s.a_e = 0;
    repeat (2) step(s);
    s = idle(); step(s);
    check("count_3", 64'(cnt), 64'd3);
    check("count_w2_3", 64'(s_cnt), 64'd3);
    s = idle(); s.long_op_d = 1'b1; s.long_busy = 1'b1;
    repeat (2) step(s);
    s = idle(); step(s);
    check("count_5", 64'(cnt), 64'd5);
    check("count_w2_sat", 64'(s_cnt), 64'd3);

    // Execute forwarding priority on x3.
    s = idle(); s.rs1_e = 3; s.we_m = 1'b1; s.a_m = 3; s.we_w = 1'b1; s.a_w = 3; step(s);
    check("fwd_M_over_W", 64'(fwda_e), 64'd2);
    s.sel_m = 1'b1; step(s);
    check("fwd_load_M_to_W", 64'(fwda_e), 64'd1);
    s.wb_valid = 1'b1; s.wb_addr = 3; step(s);
    check("fwd_long", 64'(fwda_e), 64'd3);
    s = idle(); s.we_m = 1'b1; s.we_w = 1'b1; s.wb_valid = 1'b1; step(s);
    check("fwd_x0", 64'(fwda_e), 64'd0);

    // Load-use on x7.
    s = idle(); s.rs1_d = 7; s.rs2_d = 2; s.rd_d = 1; s.wr_en_d = 1'b1;
    s.we_e = 1'b1; s.a_e = 7; s.sel_e = 1'b1; step(s);
    check("lw_stall", 64'(stall_d), 64'd1);
    s = idle(); s.rs1_d = 7; s.rs2_d = 2; s.rd_d = 1; s.wr_en_d = 1'b1;
    s.we_m = 1'b1; s.a_m = 7; s.sel_m = 1'b1; s.rs1_e = 7; step(s);
    check("lw_stall_once", 64'(stall_d), 64'd0);
    check("lw_no_fwd_M", 64'(fwda_e), 64'd0);
    s = idle(); s.rs1_e = 7; s.rs2_e = 2; s.we_w = 1'b1; s.a_w = 7; step(s);
    check("lw_fwd_W", 64'(fwda_e), 64'd1);

    // Scoreboard RAW/WAW on x9.
    s = idle(); s.long_issue_e = 1'b1; s.a_e = 9; step(s);
    s = idle(); s.rs1_d = 9; step(s);
    check("sb_pending9", 64'(pend[9]), 64'd1);
    check("sb_raw", 64'(stall_d), 64'd1);
    s = idle(); s.rd_d = 9; s.wr_en_d = 1'b1; step(s);
    check("sb_waw", 64'(stall_d), 64'd1);
    s = idle(); s.rs1_d = 9; s.wb_valid = 1'b1; s.wb_addr = 9; s.rs1_e = 9; step(s);
    check("sb_wb_cycle_stall", 64'(stall_d), 64'd1);
    check("sb_wb_fwd_long", 64'(fwda_e), 64'd3);
    s = idle(); s.rs1_d = 9; step(s);
    check("sb_released", 64'(stall_d), 64'd0);
    check("sb_cleared", 64'(pend[9]), 64'd0);

    // Set/clear collision on x4, then an issue to x0.
    s = idle(); s.wb_valid = 1'b1; s.wb_addr = 4; s.long_issue_e = 1'b1; s.a_e = 4; step(s);
    s = idle(); s.long_issue_e = 1'b1; s.a_e = 0; step(s);
    check("collision_set_wins", 64'(pend), 64'h10);
    s = idle(); s.wb_valid = 1'b1; s.wb_addr = 4; step(s);
    check("x0_ignored", 64'(pend), 64'h10);
    s = idle(); step(s);
    check("x4_cleared", 64'(pend), 64'h0);

    for (int i = 0; i < 3000; i++) begin
      step(rnd());
    end

    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
